// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate extender with a 2-entry skid buffer.
// Converts an IN_W-bit immediate to an OUT_W-bit value according to a
// 3-bit mode. The value is extended when it is accepted and stored already
// extended. Optional macro EXT_TAG_EN adds a sideband tag that travels with
// each item.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds its payload stable until that edge. in_ready and
// out_valid come straight from flops, so out_ready never reaches in_ready
// combinationally.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm,
  input  logic [2:0]       eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
`ifdef EXT_TAG_EN
  ,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out
`endif
);

`ifdef EXT_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  // One stored entry is {tag (optional), err, data}.
  localparam int ENT_W = OUT_W + 1 + (TAG_EN ? TAG_W : 0);

  // Buffer occupancy; state_q is the debug view of the FSM.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   a_q, a_d;   // output register, drives the outputs
  logic [ENT_W-1:0]   b_q, b_d;   // skid register, second-oldest item
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [OUT_W-1:0]   sext, zext, ext_data;
  logic               ext_err;
  logic [ENT_W-1:0]   new_ent;
  logic               acc, pop;

  // Extend the incoming immediate according to the mode.
  always_comb begin
    sext     = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    zext     = {{(OUT_W-IN_W){1'b0}}, imm};
    ext_data = '0;
    ext_err  = 1'b0;
    case (eop)
      3'b000:  ext_data = sext;
      3'b001:  ext_data = zext;
      3'b010:  ext_data = zext << (OUT_W - IN_W);
      3'b011:  ext_data = sext << SHIFT;
      3'b100:  ext_data = zext << SHIFT;
      default: ext_err  = 1'b1;  // reserved modes give zero data
    endcase
`ifdef EXT_TAG_EN
    new_ent = {tag_in, ext_err, ext_data};
`else
    new_ent = {ext_err, ext_data};
`endif
  end

  assign acc = in_valid & in_ready_q;
  assign pop = out_valid_q & out_ready;

  // Next-state and storage moves of the two-entry buffer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          a_d     = new_ent;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && !pop) begin
          b_d     = new_ent;
          state_d = ST_FULL;
        end else if (acc && pop) begin
          a_d     = new_ent;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          a_d     = b_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = a_q[OUT_W-1:0];
  assign out_err   = a_q[OUT_W];
`ifdef EXT_TAG_EN
  assign tag_out   = a_q[ENT_W-1 -: TAG_W];
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed bench for ext_pipe with a queue-based reference model.
// Build with +define+EXT_TAG_EN to exercise the tag sideband as well.
module tb_ext_pipe;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int SHIFT = 2;
  localparam int TAG_W = 5;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm;
  logic [2:0]       eop;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_out;

  int n_checks = 0;
  int n_pass   = 0;
  int pop_cnt  = 0;

  // Expected queue entries are {tag, err, data}.
  localparam int EW = TAG_W + 1 + OUT_W;
  logic [EW-1:0] exp_q[$];

  ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .imm      (imm),
    .eop      (eop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
`ifdef EXT_TAG_EN
    ,
    .tag_in   (tag_in),
    .tag_out  (tag_out)
`endif
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference extension from arithmetic: signed/unsigned value times a power of two, mod 2^OUT_W.
  function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] i, input logic [2:0] m);
    longint u, s, p;
    logic [OUT_W-1:0] d;
    logic err;
    u = longint'(i);
    s = i[IN_W-1] ? (u - (longint'(1) << IN_W)) : u;
    err = 1'b0;
    p = 0;
    case (m)
      3'd0: p = s;
      3'd1: p = u;
      3'd2: p = u * (longint'(1) << (OUT_W - IN_W));
      3'd3: p = s * (longint'(1) << SHIFT);
      3'd4: p = u * (longint'(1) << SHIFT);
      default: begin p = 0; err = 1'b1; end
    endcase
    d = p[OUT_W-1:0];
    return {err, d};
  endfunction

  function automatic logic [TAG_W-1:0] act_tag();
`ifdef EXT_TAG_EN
    return tag_out;
`else
    return '0;
`endif
  endfunction

  // Scoreboard: every cycle out of reset, compare against a 2-deep FIFO model.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      check("model_in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      check("model_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      if (out_valid && exp_q.size() > 0)
        check("model_payload", 64'({act_tag(), out_err, out_data}), 64'(exp_q[0]));
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        pop_cnt++;
      end
      if (in_valid && in_ready) begin
`ifdef EXT_TAG_EN
        exp_q.push_back({tag_in, model(imm, eop)});
`else
        exp_q.push_back({{TAG_W{1'b0}}, model(imm, eop)});
`endif
      end
    end
  end

  // Driver: one item into an empty buffer with out_ready high, check the one-cycle latency.
  task automatic send_and_check(input logic [IN_W-1:0] i, input logic [2:0] m,
                                input logic [OUT_W-1:0] exp_d, input logic exp_e);
    @(posedge clk); #1;
    in_valid = 1'b1; imm = i; eop = m;
    @(negedge clk);
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_valid", 64'(out_valid), 64'd1);
    check("lit_data", 64'(out_data), 64'(exp_d));
    check("lit_err", 64'(out_err), 64'(exp_e));
  endtask

  task automatic drive(input logic [IN_W-1:0] i, input logic [2:0] m, input logic [TAG_W-1:0] t);
    in_valid = 1'b1; imm = i; eop = m; tag_in = t;
  endtask

  logic [IN_W-1:0] stream_imm[8];
  int pop_start;

  initial begin
    reset = 1'b1; in_valid = 1'b0; imm = '0; eop = '0; out_ready = 1'b0; tag_in = '0;
    stream_imm[0] = 16'h0001; stream_imm[1] = 16'h8000; stream_imm[2] = 16'h7FFF;
    stream_imm[3] = 16'hFFFF; stream_imm[4] = 16'h1234; stream_imm[5] = 16'hABCD;
    stream_imm[6] = 16'h00F0; stream_imm[7] = 16'hC3C3;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
`ifdef EXT_TAG_EN
    check("rst_tag_out", 64'(tag_out), 64'd0);
`endif

    // Modes on a value with the sign bit set.
    out_ready = 1'b1;
    send_and_check(16'h8001, 3'b000, 32'hFFFF8001, 1'b0);
    send_and_check(16'h8001, 3'b001, 32'h00008001, 1'b0);
    send_and_check(16'h8001, 3'b010, 32'h80010000, 1'b0);
    send_and_check(16'h8001, 3'b011, 32'hFFFE0004, 1'b0);
    send_and_check(16'h8001, 3'b100, 32'h00020004, 1'b0);

    // Reserved modes, then a normal mode clears the error.
    send_and_check(16'h1234, 3'b101, 32'h0, 1'b1);
    send_and_check(16'h1234, 3'b110, 32'h0, 1'b1);
    send_and_check(16'h1234, 3'b111, 32'h0, 1'b1);
    send_and_check(16'h1234, 3'b000, 32'h00001234, 1'b0);

    // Backpressure: third item is held until the consumer drains.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(16'h0001, 3'b000, 5'd0);
    @(posedge clk); #1;
    drive(16'hFFFF, 3'b001, 5'd0);
    @(posedge clk); #1;
    drive(16'h8000, 3'b000, 5'd0);
    @(negedge clk);
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_head", 64'(out_data), 64'h00000001);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_hold_ready", 64'(in_ready), 64'd0);
    check("bp_hold_head", 64'(out_data), 64'h00000001);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain0", 64'(out_data), 64'h00000001);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_drain1", 64'(out_data), 64'h0000FFFF);
    check("bp_reopen", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_drain2", 64'(out_data), 64'hFFFF8000);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_empty", 64'(out_valid), 64'd0);

    // Full throughput: 8 items on 8 consecutive cycles.
    pop_start = pop_cnt;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(stream_imm[i], 3'(i % 5), 5'(i));
      @(negedge clk);
      check("stream_ready", 64'(in_ready), 64'd1);
      if (i > 0) check("stream_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("stream_done", 64'(out_valid), 64'd0);
    check("stream_count", 64'(pop_cnt - pop_start), 64'd8);

    // Reset while full drops both entries.
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive(16'h00AA, 3'b001, 5'd0);
    @(posedge clk); #1;
    drive(16'h0055, 3'b001, 5'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_full", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("frst_out_valid", 64'(out_valid), 64'd0);
    check("frst_in_ready", 64'(in_ready), 64'd1);
    check("frst_out_data", 64'(out_data), 64'd0);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("frst_no_ghost", 64'(out_valid), 64'd0);
    end
    send_and_check(16'h7FFF, 3'b000, 32'h00007FFF, 1'b0);

`ifdef EXT_TAG_EN
    // Tags follow their data under backpressure.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(16'h0001, 3'b000, 5'd3);
    @(posedge clk); #1;
    drive(16'h0002, 3'b001, 5'd17);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("tag_first", 64'(tag_out), 64'd3);
    check("tag_first_data", 64'(out_data), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("tag_first_hold", 64'(tag_out), 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    check("tag_second", 64'(tag_out), 64'd17);
    check("tag_second_data", 64'(out_data), 64'd2);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
